// File: rtl/seq_alu.sv
// seq_alu: handshaked ALU with single-cycle base operations and iterative
// multi-cycle unsigned multiply and divide.
//
// Ports:
//   clk, reset      - clock, synchronous active-high reset
//   in_valid/ready  - operand handshake; in_ready is high only in IDLE
//   in_a, in_b      - operands (in_b also carries shift amount / divisor)
//   in_op           - 4-bit operation code
//   out_valid/ready - result handshake; result held until out_ready
//   out_result      - main result (MUL low half, DIVU quotient)
//   out_result_hi   - MUL high half, DIVU remainder, 0 for other ops
//   out_bcond       - branch condition for compare ops, 0 otherwise
//   busy            - high while a MUL/DIVU iterates
module seq_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [3:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [WIDTH-1:0] out_result_hi,
  output logic             out_bcond,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  // hi/lo double as the MUL product register, the DIVU remainder/quotient
  // pair, and the visible result registers once the op finishes.
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  // Multiplicand for MUL, divisor for DIVU.
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             is_mul_q, is_mul_d;
  logic             bcond_q, bcond_d;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_bcond;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next, mul_lo_next;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] div_hi_next, div_lo_next;

  assign shamt = in_b[SHW-1:0];

  // Single-cycle operations, evaluated on the raw inputs so the result can be
  // captured on the accepting edge.
  always_comb begin
    alu_res   = '0;
    alu_bcond = 1'b0;
    case (in_op)
      4'd0:    alu_res   = in_a - in_b;
      4'd1:    alu_res   = in_a + in_b;
      4'd2:    alu_res   = in_a & in_b;
      4'd3:    alu_res   = in_a | in_b;
      4'd4:    alu_res   = in_a ^ in_b;
      4'd5:    alu_res   = in_a << shamt;
      4'd6:    alu_res   = in_a >> shamt;
      4'd7:    alu_bcond = (in_a == in_b);
      4'd8:    alu_bcond = (in_a != in_b);
      4'd9:    alu_bcond = (in_a < in_b);
      4'd10:   alu_bcond = (in_a >= in_b);
      4'd11:   alu_res   = $signed(in_a) >>> shamt;
      4'd12:   alu_bcond = ($signed(in_a) < $signed(in_b));
      4'd13:   alu_bcond = ($signed(in_a) >= $signed(in_b));
      default: alu_res   = '0;
    endcase
  end

  // One shift-add multiply step: the multiplier sits in lo and shifts out
  // LSB-first while product bits shift in from the top of the partial sum.
  always_comb begin
    mul_sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_hi_next = mul_sum[WIDTH:1];
    mul_lo_next = {mul_sum[0], lo_q[WIDTH-1:1]};
  end

  // One restoring-divide step: the dividend sits in lo and shifts MSB-first
  // into the remainder while quotient bits fill lo from the bottom. A zero
  // divisor always "fits", which naturally yields all-ones / dividend.
  always_comb begin
    div_shift   = {hi_q, lo_q[WIDTH-1]};
    div_ge      = (div_shift >= {1'b0, opnd_q});
    div_hi_next = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
    div_lo_next = {lo_q[WIDTH-2:0], div_ge};
  end

  // Next-state and datapath register updates.
  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_mul_d = is_mul_q;
    bcond_d  = bcond_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_op == 4'd14 || in_op == 4'd15) begin
            is_mul_d = (in_op == 4'd14);
            opnd_d   = (in_op == 4'd14) ? in_a : in_b;
            lo_d     = (in_op == 4'd14) ? in_b : in_a;
            hi_d     = '0;
            bcond_d  = 1'b0;
            cnt_d    = SHW'(WIDTH - 1);
            state_d  = BUSY;
          end else begin
            lo_d    = alu_res;
            hi_d    = '0;
            bcond_d = alu_bcond;
            state_d = DONE;
          end
        end
      end
      BUSY: begin
        hi_d  = is_mul_q ? mul_hi_next : div_hi_next;
        lo_d  = is_mul_q ? mul_lo_next : div_lo_next;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_mul_q <= 1'b0;
      bcond_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_mul_q <= is_mul_d;
      bcond_q  <= bcond_d;
    end
  end

  assign in_ready      = (state_q == IDLE);
  assign busy          = (state_q == BUSY);
  assign out_valid     = (state_q == DONE);
  assign out_result    = lo_q;
  assign out_result_hi = hi_q;
  assign out_bcond     = bcond_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: drives seq_alu with directed and random transactions and
// compares every cycle against an arithmetic reference model.
module tb_seq_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_result_hi;
  logic        out_bcond;
  logic        busy;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  longint      cyc = 0;
  longint      accCyc = 0;
  bit          modelKnown = 0;
  bit          pending = 0;
  bit          fresh = 0;
  logic [31:0] expRes, expHi;
  logic        expBcond;
  int          expLat;

  seq_alu #(.WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .in_op         (in_op),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_result_hi (out_result_hi),
    .out_bcond     (out_bcond),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Results straight from the operation definitions.
  task automatic computeModel(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                              output logic [31:0] res, output logic [31:0] hi,
                              output logic bc, output int lat);
    logic [31:0] ones;
    logic [63:0] prod;
    int          sh;
    ones = 32'hFFFF_FFFF;
    sh   = int'(b[4:0]);
    res  = 32'h0;
    hi   = 32'h0;
    bc   = 1'b0;
    lat  = 1;
    case (op)
      4'd0:  res = a - b;
      4'd1:  res = a + b;
      4'd2:  res = a & b;
      4'd3:  res = a | b;
      4'd4:  res = a ^ b;
      4'd5:  res = a << sh;
      4'd6:  res = a >> sh;
      4'd7:  bc  = (a == b);
      4'd8:  bc  = (a != b);
      4'd9:  bc  = (a < b);
      4'd10: bc  = (a >= b);
      4'd11: res = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
      4'd12: bc  = ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000));
      4'd13: bc  = ((a ^ 32'h8000_0000) >= (b ^ 32'h8000_0000));
      4'd14: begin
        prod = {32'h0, a} * {32'h0, b};
        res  = prod[31:0];
        hi   = prod[63:32];
        lat  = 33;
      end
      default: begin
        if (b == 32'h0) begin
          res = ones;
          hi  = a;
        end else begin
          res = a / b;
          hi  = a % b;
        end
        lat = 33;
      end
    endcase
  endtask

  // Model update at each rising edge, from bench-driven inputs only.
  always @(posedge clk) begin
    if (reset) begin
      modelKnown = 1;
      pending    = 0;
      fresh      = 1;
    end else if (modelKnown) begin
      if (!pending) begin
        if (in_valid) begin
          computeModel(in_a, in_b, in_op, expRes, expHi, expBcond, expLat);
          accCyc  = cyc;
          pending = 1;
          fresh   = 0;
        end
      end else if ((cyc - accCyc) >= longint'(expLat) && out_ready) begin
        pending = 0;
      end
    end
    cyc++;
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (modelKnown) begin
      checkOutput("in_ready", 64'(in_ready), 64'(!pending));
      checkOutput("busy", 64'(busy), 64'(pending && (cyc - accCyc) < longint'(expLat)));
      checkOutput("out_valid", 64'(out_valid), 64'(pending && (cyc - accCyc) >= longint'(expLat)));
      if (pending && (cyc - accCyc) >= longint'(expLat)) begin
        checkOutput("out_result", 64'(out_result), 64'(expRes));
        checkOutput("out_result_hi", 64'(out_result_hi), 64'(expHi));
        checkOutput("out_bcond", 64'(out_bcond), 64'(expBcond));
      end else if (fresh) begin
        checkOutput("rst_result", 64'(out_result), 64'h0);
        checkOutput("rst_result_hi", 64'(out_result_hi), 64'h0);
        checkOutput("rst_bcond", 64'(out_bcond), 64'h0);
      end
    end
  end

  // One full transaction: present, wait for the result (injecting ignored
  // in_valid noise meanwhile), hold backpressure, then consume.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                               input int hold, output logic [31:0] res, output logic [31:0] hi,
                               output logic bc, output int lat);
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    lat      = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (out_valid === 1'b1) break;
      #1;
      in_valid = 1'($urandom_range(0, 1));
      in_a     = $urandom;
      in_b     = $urandom;
      in_op    = 4'($urandom);
    end
    in_valid = 1'b0;
    if (lat >= 100) checkOutput("valid_timeout", 64'(out_valid), 64'h1);
    res = out_result;
    hi  = out_result_hi;
    bc  = out_bcond;
    repeat (hold) @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    out_ready = 1'b0;
  endtask

  task automatic expectLit(input string name, input logic [31:0] res, input logic [31:0] hi,
                           input logic bc, input int lat, input logic [31:0] eRes,
                           input logic [31:0] eHi, input logic eBc, input int eLat);
    checkOutput({name, "_res"}, 64'(res), 64'(eRes));
    checkOutput({name, "_hi"}, 64'(hi), 64'(eHi));
    checkOutput({name, "_bcond"}, 64'(bc), 64'(eBc));
    checkOutput({name, "_lat"}, 64'(lat), 64'(eLat));
  endtask

  initial begin
    logic [31:0] r, h, opA, opB;
    logic        bc;
    int          lat;

    reset     = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;

    applyStimulus(32'hFFFF_FFFF, 32'h1, 4'd1, 0, r, h, bc, lat);
    expectLit("add_wrap", r, h, bc, lat, 32'h0, 32'h0, 1'b0, 1);
    @(negedge clk);
    checkOutput("add_release_ready", 64'(in_ready), 64'h1);

    applyStimulus(32'h8000_0000, 32'h24, 4'd11, 0, r, h, bc, lat);
    expectLit("sra", r, h, bc, lat, 32'hF800_0000, 32'h0, 1'b0, 1);
    applyStimulus(32'h8000_0000, 32'h24, 4'd6, 1, r, h, bc, lat);
    expectLit("srl", r, h, bc, lat, 32'h0800_0000, 32'h0, 1'b0, 1);
    applyStimulus(32'hFFFF_FFFF, 32'h1, 4'd12, 0, r, h, bc, lat);
    expectLit("blt", r, h, bc, lat, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus(32'hFFFF_FFFF, 32'h1, 4'd9, 0, r, h, bc, lat);
    expectLit("bltu", r, h, bc, lat, 32'h0, 32'h0, 1'b0, 1);
    applyStimulus(32'h5, 32'h5, 4'd13, 0, r, h, bc, lat);
    expectLit("bge", r, h, bc, lat, 32'h0, 32'h0, 1'b1, 1);
    applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd14, 2, r, h, bc, lat);
    expectLit("mul", r, h, bc, lat, 32'h1, 32'hFFFF_FFFE, 1'b0, 33);
    applyStimulus(32'd100, 32'd7, 4'd15, 0, r, h, bc, lat);
    expectLit("divu", r, h, bc, lat, 32'd14, 32'd2, 1'b0, 33);
    applyStimulus(32'h1234, 32'h0, 4'd15, 0, r, h, bc, lat);
    expectLit("divu_zero", r, h, bc, lat, 32'hFFFF_FFFF, 32'h1234, 1'b0, 33);
    applyStimulus(32'h0F0F_1234, 32'hFF00_00FF, 4'd4, 10, r, h, bc, lat);
    expectLit("xor_hold", r, h, bc, lat, 32'hF00F_12CB, 32'h0, 1'b0, 1);

    // Reset five cycles into a MUL, with in_valid asserted during reset.
    @(posedge clk);
    #2;
    in_valid = 1'b1;
    in_a     = 32'h1234_5678;
    in_b     = 32'h9ABC_DEF0;
    in_op    = 4'd14;
    @(posedge clk);
    #2;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    reset    = 1'b1;
    in_valid = 1'b1;
    in_op    = 4'd1;
    @(posedge clk);
    #2;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("midrst_valid", 64'(out_valid), 64'h0);
    checkOutput("midrst_ready", 64'(in_ready), 64'h1);
    applyStimulus(32'd40, 32'd2, 4'd1, 0, r, h, bc, lat);
    expectLit("post_rst_add", r, h, bc, lat, 32'd42, 32'h0, 1'b0, 1);

    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0:       opA = $urandom;
        1:       opA = $urandom_range(0, 3);
        2:       opA = 32'hFFFF_FFFF;
        default: opA = 32'h8000_0000 | $urandom_range(0, 255);
      endcase
      case ($urandom_range(0, 3))
        0:       opB = $urandom;
        1:       opB = $urandom_range(0, 3);
        2:       opB = 32'hFFFF_FFFF;
        default: opB = opA;
      endcase
      applyStimulus(opA, opB, 4'($urandom), $urandom_range(0, 3), r, h, bc, lat);
    end

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, failed so far %0d", failCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
Parametrised, handshaked successor to the single-cycle datapath ALU. Keeps the 11 base operations (arith, logic, shift, branch compare) with registered one-cycle latency. Adds arithmetic right shift, signed branch compares, and iterative multi-cycle MUL and DIVU.
Sits between the decode/operand stage and writeback. Uses a valid/ready handshake on both sides so the pipeline can stall on long operations.

Parameters:
WIDTH, 32, operand/result width; power of two, >= 8
SHW, $clog2(WIDTH), localparam; shift-amount bits taken from in_b[SHW-1:0]

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept; high only in IDLE
in_a  input  WIDTH  operand 1
in_b  input  WIDTH  operand 2 / shift amount / divisor
in_op  input  4  operation code
out_valid  output  1  result available; held until out_ready
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result (MUL low half, DIVU quotient)
out_result_hi  output  WIDTH  MUL high half, DIVU remainder, 0 otherwise
out_bcond  output  1  branch condition (ops 7-10, 12, 13), else 0
busy  output  1  high in BUSY state

Behaviour:
- Op codes (a=in_a, b=in_b, all unsigned unless noted):
  0 SUB a-b; 1 ADD a+b; 2 AND; 3 OR; 4 XOR; 5 SLL a<<b[SHW-1:0]; 6 SRL logical; 7 BEQ; 8 BNE; 9 BLTU a<b; 10 BGEU a>=b;
  11 SRA signed arithmetic shift by b[SHW-1:0]; 12 BLT signed a<b; 13 BGE signed a>=b;
  14 MUL unsigned 2*WIDTH product {hi,lo}; 15 DIVU quotient/remainder.
- Add/sub wrap modulo 2^WIDTH; no carry/overflow output.
- Branch ops (7-10, 12, 13): out_result=0, out_result_hi=0. All other ops: out_bcond=0.
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. A transfer occurs when in_valid && in_ready at a rising edge; a, b and op are latched.
  - Ops 0-13: compute and go to DONE. out_valid is high the cycle after acceptance (latency 1).
  - Ops 14-15: go to BUSY and load iteration counter with WIDTH-1.
- BUSY: one shift-add (MUL) or restoring-subtract (DIVU) step per cycle; counter decrements.
  - On the step where counter==0, go to DONE. out_valid rises WIDTH+1 cycles after acceptance.
  - in_ready=0 and in_valid is ignored while in BUSY.
- DONE: out_valid=1; out_result, out_result_hi and out_bcond are stable.
  - out_ready=1 at an edge: go to IDLE; out_valid drops the next cycle. No same-cycle re-accept.
  - out_ready=0: hold indefinitely with outputs unchanged.
- DIVU by zero: quotient = all ones, remainder = a. Still takes the full WIDTH+1 latency.
- MUL/DIVU with operand 0 or 1 still take the full iteration count (no early exit).
- Reset (any state, including mid-BUSY or DONE): next state IDLE; the in-flight op is discarded.
  - Reset values: out_valid=0, out_result=0, out_result_hi=0, out_bcond=0, busy=0, in_ready=1 after reset.
- Reset takes priority over handshake: in_valid during the reset cycle is not accepted.
- Outputs are registered; no combinational path from in_* to out_*. in_ready and busy decode directly from state.

Test Plan:
- Reset then ADD a=0xFFFFFFFF, b=1 -> out_valid next cycle, out_result=0x00000000, out_result_hi=0, out_bcond=0; then out_ready=1 -> in_ready=1 the following cycle.
- SRA a=0x80000000, b=0x00000024 (shamt 4); SRL same operands -> 0xF8000000 and 0x08000000 respectively.
- BLT a=0xFFFFFFFF (-1), b=1 -> bcond=1; BLTU same operands -> bcond=0; BGE a=5, b=5 -> bcond=1.
- MUL a=0xFFFFFFFF, b=0xFFFFFFFF -> out_valid exactly 33 cycles after accept; lo=0x00000001, hi=0xFFFFFFFE; in_ready=0 throughout BUSY.
- DIVU a=100, b=7 -> q=14, r=2; DIVU a=0x1234, b=0 -> q=0xFFFFFFFF, r=0x1234; latency 33 cycles for both.
- Backpressure and reset: hold out_ready=0 for 10 cycles in DONE -> outputs unchanged. Separately, assert reset 5 cycles into a MUL -> IDLE next cycle, out_valid=0, and a fresh ADD completes correctly.
